// File: rtl/merge_sorter_tree.sv
// Streaming 2^W_LOG-way merge sorter: per-lane leaf FIFOs feed a binary tree of
// compare/select nodes, each with a small output FIFO; the root drains to DOT/DOTEN.
module merge_sorter_tree #(
    parameter int unsigned W_LOG = 10,
    parameter int unsigned DATW  = 64,
    parameter int unsigned KEYW  = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STALL,
    input  logic [(DATW<<W_LOG)-1:0] DIN,
    input  logic [(1<<W_LOG)-1:0]    DINEN,
    output logic [(1<<W_LOG)-1:0]    FULL,
    output logic [DATW-1:0]          DOT,
    output logic                     DOTEN
);
    localparam int unsigned N = 1 << W_LOG;

    // Heap numbering: 1 is the root, node k has children 2k (left) and 2k+1,
    // lane i is entry N+i. Every entry exposes its FIFO head, emptiness and pop.
    logic [2*N-1:1]           empty_w;
    logic [2*N-1:1]           pop_w;
    logic [2*N-1:1][DATW-1:0] head_w;

    logic [DATW-1:0] dot_q;
    logic            doten_q;

    for (genvar i = 0; i < N; i++) begin : g_leaf
        logic [DATW-1:0] mem_q [4];
        logic [1:0]      wr_q;
        logic [1:0]      rd_q;
        logic [2:0]      cnt_q;
        logic [2:0]      cnt_d;
        logic            full_q;
        logic            push;

        assign push          = DINEN[i] & ~full_q;
        assign cnt_d         = cnt_q + {2'b00, push} - {2'b00, pop_w[N+i]};
        assign empty_w[N+i]  = (cnt_q == 3'd0);
        assign head_w[N+i]   = mem_q[rd_q];
        assign FULL[i]       = full_q;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                wr_q   <= 2'd0;
                rd_q   <= 2'd0;
                cnt_q  <= 3'd0;
                full_q <= 1'b0;
            end else begin
                if (push) wr_q <= wr_q + 2'd1;
                if (pop_w[N+i]) rd_q <= rd_q + 2'd1;
                cnt_q  <= cnt_d;
                // One entry of slack lets a producer use ~FULL directly.
                full_q <= (cnt_d >= 3'd3);
            end
        end

        always_ff @(posedge CLK) begin
            if (push) mem_q[wr_q] <= DIN[DATW*i +: DATW];
        end
    end

    for (genvar k = 1; k < N; k++) begin : g_node
        logic [DATW-1:0] mem_q [2];
        logic            wr_q;
        logic            rd_q;
        logic [1:0]      cnt_q;
        logic [1:0]      cnt_d;
        logic            take_right;
        logic            fire;

        // Ties go left, so equal keys keep lower-lane-first order.
        assign take_right = head_w[2*k+1][KEYW-1:0] < head_w[2*k][KEYW-1:0];
        assign fire       = ~empty_w[2*k] & ~empty_w[2*k+1] & (cnt_q != 2'd2);
        assign pop_w[2*k]   = fire & ~take_right;
        assign pop_w[2*k+1] = fire & take_right;
        assign cnt_d      = cnt_q + {1'b0, fire} - {1'b0, pop_w[k]};
        assign empty_w[k] = (cnt_q == 2'd0);
        assign head_w[k]  = mem_q[rd_q];

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                wr_q  <= 1'b0;
                rd_q  <= 1'b0;
                cnt_q <= 2'd0;
            end else begin
                if (fire) wr_q <= ~wr_q;
                if (pop_w[k]) rd_q <= ~rd_q;
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge CLK) begin
            if (fire) mem_q[wr_q] <= take_right ? head_w[2*k+1] : head_w[2*k];
        end
    end

    assign pop_w[1] = ~empty_w[1] & ~STALL;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dot_q   <= '0;
            doten_q <= 1'b0;
        end else begin
            doten_q <= pop_w[1];
            if (pop_w[1]) dot_q <= head_w[1];
        end
    end

    assign DOT   = dot_q;
    assign DOTEN = doten_q;

endmodule

// File: tb/tb_merge_sorter_tree.sv
// Bench for merge_sorter_tree: small trees driven from a vector table and hand sequences,
// a 1024-lane tree driven by free-running producers against a sorted-merge scoreboard.
module tb_merge_sorter_tree;
    localparam int W10 = 10;
    localparam int N10 = 1 << W10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst1, rst2, rst10;
    logic                 stall1, stall2, stall10;
    logic [127:0]         din1;
    logic [1:0]           en1, full1;
    logic [63:0]          dot1;
    logic                 doten1;
    logic [255:0]         din2;
    logic [3:0]           en2, full2;
    logic [63:0]          dot2;
    logic                 doten2;
    logic [64*N10-1:0]    din10;
    logic [N10-1:0]       en10, full10;
    logic [63:0]          dot10;
    logic                 doten10;

    merge_sorter_tree #(.W_LOG(1), .DATW(64), .KEYW(32)) u_dut1 (
        .CLK(clk), .RST(rst1), .STALL(stall1), .DIN(din1), .DINEN(en1),
        .FULL(full1), .DOT(dot1), .DOTEN(doten1)
    );
    merge_sorter_tree #(.W_LOG(2), .DATW(64), .KEYW(32)) u_dut2 (
        .CLK(clk), .RST(rst2), .STALL(stall2), .DIN(din2), .DINEN(en2),
        .FULL(full2), .DOT(dot2), .DOTEN(doten2)
    );
    merge_sorter_tree #(.W_LOG(W10), .DATW(64), .KEYW(32)) u_dut10 (
        .CLK(clk), .RST(rst10), .STALL(stall10), .DIN(din10), .DINEN(en10),
        .FULL(full10), .DOT(dot10), .DOTEN(doten10)
    );

    typedef struct {
        bit          rst;
        bit          en0;
        logic [63:0] d0;
        bit          en1;
        logic [63:0] d1;
        int          nexp;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    int          n_cmp;
    int          n_fail;
    int          out1, out2, out10;
    bit          prod10, arm10;
    int unsigned nk [N10];
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];
    logic [63:0] q10 [$];
    vec_t        tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit en0, input logic [63:0] d0,
                                input bit en1, input logic [63:0] d1, input int nexp,
                                input logic [63:0] e0, input logic [63:0] e1);
        vec_t v;
        v.rst = rst; v.en0 = en0; v.d0 = d0; v.en1 = en1; v.d1 = d1;
        v.nexp = nexp; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Producers for the big tree: lane i emits {FFFFFFFF, 1024-i + 1024*m} whenever not full;
    // each accepted record goes into the model queue kept sorted by key.
    task automatic drive10();
        logic [63:0] rec;
        logic [63:0] tmp;
        int idx;
        if (!prod10) return;
        for (int i = N10 - 1; i >= 0; i--) begin
            en10[i] = ~full10[i];
            if (!full10[i]) begin
                rec = {32'hFFFF_FFFF, nk[i]};
                din10[64*i +: 64] = rec;
                idx = q10.size();
                while (idx > 0) begin
                    tmp = q10[idx-1];
                    if (tmp[31:0] <= nk[i]) break;
                    idx--;
                end
                q10.insert(idx, rec);
                nk[i] += N10;
            end
        end
    endtask

    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (doten1 === 1'b1) begin
            if (q1.size() == 0) check("dut1 DOTEN with nothing expected", {63'd0, doten1}, 64'd0);
            else begin
                e = q1.pop_front();
                check("dut1 DOT", dot1, e);
                out1++;
            end
        end
        if (doten2 === 1'b1) begin
            if (q2.size() == 0) check("dut2 DOTEN with nothing expected", {63'd0, doten2}, 64'd0);
            else begin
                e = q2.pop_front();
                check("dut2 DOT", dot2, e);
            end
            out2++;
        end
        if (arm10) check("dut10 DOTEN vs STALL", {63'd0, doten10}, {63'd0, !stall10});
        if (doten10 === 1'b1) begin
            if (q10.size() == 0) check("dut10 DOTEN with nothing expected", {63'd0, doten10}, 64'd0);
            else begin
                e = q10.pop_front();
                check("dut10 DOT", dot10, e);
            end
            out10++;
        end
        drive10();
    endtask

    task automatic drain(input int which);
        int t = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && t < 30) begin
            tick();
            t++;
        end
        check("drain of expected records", 64'((which == 1) ? q1.size() : q2.size()), 64'd0);
        repeat (5) tick();
    endtask

    task automatic restart10();
        rst10 = 1'b1;
        q10.delete();
        out10 = 0;
        for (int i = 0; i < N10; i++) nk[i] = N10 - i;
        prod10 = 1'b1;
        drive10();
        for (int j = 0; j < W10 + 5 && out10 == 0; j++) tick();
        check("dut10 first DOTEN within latency bound", {63'd0, out10 != 0}, 64'd1);
        for (int j = 0; j < 200 && out10 < 64; j++) tick();
        arm10 = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_fail = 0; out1 = 0; out2 = 0; out10 = 0;
        prod10 = 1'b0; arm10 = 1'b0;
        rst1 = 1'b0; rst2 = 1'b0; rst10 = 1'b0;
        stall1 = 1'b0; stall2 = 1'b0; stall10 = 1'b0;
        din1 = '0; din2 = '0; din10 = '0;
        en1 = '0; en2 = '0; en10 = '0;

        tbl[0] = mk(1'b1, 1'b1, {32'hA000_0000, 32'd1}, 1'b1, {32'hB000_0000, 32'd2}, 2,
                    {32'hA000_0000, 32'd1}, {32'hB000_0000, 32'd2});
        tbl[1] = mk(1'b0, 1'b1, {32'hA000_0000, 32'd3}, 1'b1, {32'hB000_0000, 32'd4}, 2,
                    {32'hA000_0000, 32'd3}, {32'hB000_0000, 32'd4});
        tbl[2] = mk(1'b0, 1'b1, {32'hA000_0000, 32'd5}, 1'b1, {32'hB000_0000, 32'd6}, 1,
                    {32'hA000_0000, 32'd5}, 64'd0);
        tbl[3] = mk(1'b0, 1'b1, {32'hA000_0000, 32'd7}, 1'b0, 64'd0, 1,
                    {32'hB000_0000, 32'd6}, 64'd0);
        tbl[4] = mk(1'b1, 1'b1, {32'hC000_0001, 32'd7}, 1'b1, {32'hD000_0002, 32'd7}, 1,
                    {32'hC000_0001, 32'd7}, 64'd0);
        tbl[5] = mk(1'b0, 1'b1, {32'hC000_0003, 32'd9}, 1'b0, 64'd0, 1,
                    {32'hD000_0002, 32'd7}, 64'd0);

        // Reset state of every instance, with write enables asserted to show they are ignored.
        en1 = '1; en2 = '1; din1 = '1; din2 = '1;
        tick();
        tick();
        check("dut1 reset DOTEN", {63'd0, doten1}, 64'd0);
        check("dut1 reset FULL", {62'd0, full1}, 64'd0);
        check("dut2 reset DOTEN", {63'd0, doten2}, 64'd0);
        check("dut2 reset FULL", {60'd0, full2}, 64'd0);
        check("dut2 reset DOT", dot2, 64'd0);
        check("dut10 reset DOTEN", {63'd0, doten10}, 64'd0);
        check("dut10 reset FULL any", {63'd0, |full10}, 64'd0);
        en1 = '0; en2 = '0;

        // Two-lane merge and tie ordering from the vector table.
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].rst) begin
                drain(1);
                rst1 = 1'b0;
                #1;
                check("dut1 DOTEN in reset", {63'd0, doten1}, 64'd0);
                check("dut1 DOT in reset", dot1, 64'd0);
                tick();
                rst1 = 1'b1;
            end
            en1  = {tbl[r].en1, tbl[r].en0};
            din1 = {tbl[r].d1, tbl[r].d0};
            if (tbl[r].nexp > 0) q1.push_back(tbl[r].e0);
            if (tbl[r].nexp > 1) q1.push_back(tbl[r].e1);
            tick();
        end
        en1 = '0;
        drain(1);
        check("dut1 record count", 64'(out1), 64'd8);

        // Four lanes, lane 3 starved: nothing may come out until it receives a record.
        rst2 = 1'b1;
        en2  = 4'b0111;
        din2 = {64'd0, {32'h2222_0000, 32'd3}, {32'h1111_0000, 32'd2}, {32'h0000_0000, 32'd1}};
        tick();
        din2 = {64'd0, {32'h2222_0000, 32'd7}, {32'h1111_0000, 32'd6}, {32'h0000_0000, 32'd5}};
        tick();
        en2 = 4'b0000;
        repeat (20) tick();
        check("dut2 silent while lane 3 empty", 64'(out2), 64'd0);
        en2 = 4'b1000;
        din2 = {{32'h3333_0000, 32'hFFFF_FFFF}, 192'd0};
        q2.push_back({32'h0000_0000, 32'd1});
        q2.push_back({32'h1111_0000, 32'd2});
        q2.push_back({32'h2222_0000, 32'd3});
        q2.push_back({32'h0000_0000, 32'd5});
        tick();
        en2 = 4'b0000;
        drain(2);
        check("dut2 record count", 64'(out2), 64'd4);

        // 1024-lane interleaved stream, backpressure, then reset mid-stream.
        restart10();
        repeat (60) tick();
        stall10 = 1'b1;
        repeat (20) tick();
        check("dut10 all FULL under stall", {63'd0, &full10}, 64'd1);
        stall10 = 1'b0;
        repeat (60) tick();

        rst10 = 1'b0;
        arm10 = 1'b0;
        prod10 = 1'b0;
        en10 = '1;
        din10 = '1;
        #1;
        check("dut10 DOTEN at reset", {63'd0, doten10}, 64'd0);
        check("dut10 FULL at reset", {63'd0, |full10}, 64'd0);
        check("dut10 DOT at reset", dot10, 64'd0);
        tick();
        tick();
        check("dut10 DOTEN held in reset", {63'd0, doten10}, 64'd0);
        check("dut10 FULL held in reset", {63'd0, |full10}, 64'd0);
        restart10();
        repeat (40) tick();
        arm10 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
